// File: rtl/fx_pixcache_pkg.sv
// Shared types and helpers for the planar pixel cache: flush FSM states,
// bpp_mode encodings and the plane count used for each mode.
package fx_pixcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] BPP_2    = 2'd0;
    localparam logic [1:0] BPP_4    = 2'd1;
    localparam logic [1:0] BPP_8    = 2'd2;
    localparam logic [1:0] BPP_RSVD = 2'd3;

    // Reserved mode behaves as 8bpp; result is capped at the planes actually built.
    function automatic int planes_for_mode(input logic [1:0] mode, input int max_planes);
        int n;
        case (mode)
            BPP_2:   n = 2;
            BPP_4:   n = 4;
            default: n = 8;
        endcase
        return (n > max_planes) ? max_planes : n;
    endfunction

endpackage

// File: rtl/fx_pixel_plane_word.sv
// One bit-plane word of the cache row: single-column writes from the plot path
// and a masked merge that keeps dirty columns and takes the rest from RAM.
module fx_pixel_plane_word #(
    parameter int PIX = 8,
    parameter int XW  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           col_we,
    input  logic [XW-1:0]  col_x,
    input  logic           col_bit,
    input  logic           merge_en,
    input  logic [PIX-1:0] rdata,
    input  logic [PIX-1:0] mask,
    output logic [PIX-1:0] word
);

    localparam logic [XW-1:0] XMAX = XW'(PIX - 1);

    // Column 0 lives in the MSB of the plane word.
    logic [XW-1:0] bit_idx;
    assign bit_idx = XMAX - col_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
        end else if (merge_en) begin
            word <= (word & mask) | (rdata & ~mask);
        end else if (col_we) begin
            word[bit_idx] <= col_bit;
        end
    end

endmodule

// File: rtl/fx_pixel_cache_planar.sv
// Planar pixel cache: gathers plotted pixels of one row, then flushes them as
// plane words to screen RAM, reading back and merging partially written rows.
module fx_pixel_cache_planar
    import fx_pixcache_pkg::*;
#(
    parameter int PIX     = 8,
    parameter int NPLANES = 8,
    parameter int TAGW    = 13,
    localparam int XW     = (PIX > 1) ? $clog2(PIX) : 1,
    localparam int PW     = (NPLANES > 1) ? $clog2(NPLANES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         bpp_mode,
    input  logic               plot_valid,
    output logic               plot_ready,
    input  logic [XW-1:0]      plot_x,
    input  logic [TAGW-1:0]    plot_tag,
    input  logic [NPLANES-1:0] plot_color,
    input  logic               flush_req,
    output logic               busy,
    output logic               ram_req,
    output logic               ram_we,
    output logic [TAGW-1:0]    ram_tag,
    output logic [PW-1:0]      ram_plane,
    output logic [PIX-1:0]     ram_wdata,
    input  logic [PIX-1:0]     ram_rdata,
    input  logic               ram_ack
);

    state_t state, next_state;

    logic [PIX-1:0]  dirty;
    logic [TAGW-1:0] tag;
    logic [PW-1:0]   plane_idx;
    logic [PW-1:0]   last_plane;
    logic            req_on;
    logic [PIX-1:0]  words [NPLANES];

    logic           full, tag_miss, accept, miss, flush_go;
    logic           ack_hit, last_ack, merge_hit;
    logic [PIX-1:0] x_mask, dirty_upd;

    assign full      = &dirty;
    assign tag_miss  = (dirty != '0) && (plot_tag != tag);
    assign accept    = plot_valid && plot_ready;
    assign miss      = plot_valid && (state == IDLE) && !full && tag_miss;
    assign x_mask    = {1'b1, {(PIX-1){1'b0}}} >> plot_x;
    assign dirty_upd = accept ? (dirty | x_mask) : dirty;
    assign flush_go  = flush_req && (dirty_upd != '0);
    assign ack_hit   = req_on && ram_ack;
    assign last_ack  = ack_hit && (plane_idx == last_plane);
    assign merge_hit = (state == READ) && ack_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (full) begin
                    next_state = WRITE;
                end else if (miss) begin
                    next_state = READ;
                end else if (flush_go) begin
                    next_state = (&dirty_upd) ? WRITE : READ;
                end
            end
            READ:    if (last_ack) next_state = WRITE;
            WRITE:   if (last_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        plot_ready = (state == IDLE) && !full && !tag_miss;
        busy       = (state != IDLE);
        ram_req    = req_on;
        ram_we     = req_on && (state == WRITE);
        ram_tag    = tag;
        ram_plane  = plane_idx;
        ram_wdata  = ram_we ? words[plane_idx] : '0;
    end

    // Sequencing: one idle setup cycle on flush entry, then back-to-back accesses;
    // the READ->WRITE hand-over keeps the request up for plane 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty      <= '0;
            tag        <= '0;
            plane_idx  <= '0;
            last_plane <= '0;
            req_on     <= 1'b0;
        end else begin
            if (accept) begin
                dirty <= dirty_upd;
                tag   <= plot_tag;
            end
            if ((state == IDLE) && (next_state != IDLE)) begin
                last_plane <= PW'(planes_for_mode(bpp_mode, NPLANES) - 1);
                plane_idx  <= '0;
                req_on     <= 1'b0;
            end else if (state != IDLE) begin
                if (!req_on) begin
                    req_on <= 1'b1;
                end else if (ram_ack) begin
                    if (plane_idx == last_plane) begin
                        plane_idx <= '0;
                        if (state == WRITE) begin
                            req_on <= 1'b0;
                            dirty  <= '0;
                        end
                    end else begin
                        plane_idx <= plane_idx + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NPLANES; p++) begin : g_plane
        fx_pixel_plane_word #(
            .PIX (PIX),
            .XW  (XW)
        ) u_word (
            .clk      (clk),
            .reset    (reset),
            .col_we   (accept),
            .col_x    (plot_x),
            .col_bit  (plot_color[p]),
            .merge_en (merge_hit && (plane_idx == PW'(p))),
            .rdata    (ram_rdata),
            .mask     (dirty),
            .word     (words[p])
        );
    end

endmodule
